// File: rtl/ctrl_uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_uart_tx_fifo_pkg
// Description : Shared definitions for the buffered UART transmitter.
//               Holds the default bit period, serializer state codes and
//               the baud reload helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_uart_tx_fifo_pkg;

    // 115200 baud from a 50 MHz system clock
    localparam logic [8:0] c_txd_cnt_default = 9'd434;

    // Serializer state codes
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    // Index of the last data bit of an 8N1 frame
    localparam logic [2:0] c_last_bit = 3'd7;

    // Down-counter reload: a bit lasts cnt clocks when counting cnt-1..0
    function automatic logic [8:0] baud_reload(input logic [8:0] cnt);
        return cnt - 9'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_fifo_sync
// Description : Generic single-clock FIFO, depth 2**AW, DW-bit entries.
//               Pointers are AW+1 bits so full/empty come straight from the
//               registered pointers. Read data is registered on pop.
// Ports       : clk, rst_n     - clock, async active-low reset
//               push, push_dat - write strobe and data (ignored when full)
//               pop            - read strobe (ignored when empty)
//               flush          - synchronous clear, wins over push/pop
//               rd_dat         - entry captured by the most recent pop
//               full, empty    - occupancy flags
//               level          - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_fifo_sync #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rd_dat;
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_wr_en;
    logic          w_rd_en;

    // Equal low bits with differing wrap bit means the writer lapped the reader
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign level = r_wr_ptr - r_rd_ptr;

    assign w_wr_en = push && !full  && !flush;
    assign w_rd_en = pop  && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage and read register carry no reset
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= push_dat;
        if (w_rd_en) r_rd_dat <= r_mem[r_rd_ptr[AW-1:0]];
    end

    assign rd_dat = r_rd_dat;

endmodule
`default_nettype wire

// File: rtl/ctrl_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_uart_tx_fifo
// Description : Buffered 8N1 UART transmitter. Register writes push bytes
//               into a FIFO; a serializer drains it onto uart_txd with no
//               idle gap between back-to-back frames.
// Ports       : clk, rst_n  - clock, async active-low reset
//               push        - enqueue strobe, push_dat sampled when high
//               flush       - clears FIFO and overflow flag
//               full, empty - FIFO flags
//               level       - queued bytes (excludes byte in flight)
//               ovf         - sticky: a push was dropped while full
//               tx_busy     - a frame is being shifted out
//               uart_txd    - registered serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_uart_tx_fifo
    import ctrl_uart_tx_fifo_pkg::*;
#(
    parameter int         AW      = 4,
    parameter logic [8:0] TXD_CNT = c_txd_cnt_default
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  push_dat,
    input  logic        flush,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        ovf,
    output logic        tx_busy,
    output logic        uart_txd
);

    localparam logic [8:0] c_baud_reload = baud_reload(TXD_CNT);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [8:0] r_baud;
    logic [8:0] w_baud_nxt;
    logic [2:0] r_bitcnt;
    logic [2:0] w_bitcnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic       r_txd;
    logic       w_txd_nxt;
    logic       r_ovf;
    logic       w_pop;
    logic       w_baud_zero;
    logic [7:0] w_rd_dat;
    logic       w_full;
    logic       w_empty;

    ctrl_fifo_sync #(
        .DW (8),
        .AW (AW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (w_pop),
        .flush    (flush),
        .rd_dat   (w_rd_dat),
        .full     (w_full),
        .empty    (w_empty),
        .level    (level)
    );

    assign w_baud_zero = (r_baud == 9'd0);

    // Next-state / datapath logic. The popped byte lands in the FIFO read
    // register one clock after the pop, so it is copied into the shifter at
    // the end of the start bit rather than at the pop itself.
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_pop        = 1'b0;
        w_txd_nxt    = 1'b1;

        case (r_state)
            c_st_idle: begin
                w_txd_nxt = 1'b1;
                if (!w_empty && !flush) begin
                    w_pop        = 1'b1;
                    w_state_nxt  = c_st_start;
                    w_baud_nxt   = c_baud_reload;
                    w_bitcnt_nxt = 3'd0;
                end
            end
            c_st_start: begin
                w_txd_nxt = 1'b0;
                if (w_baud_zero) begin
                    w_state_nxt = c_st_data;
                    w_baud_nxt  = c_baud_reload;
                    w_shift_nxt = w_rd_dat;
                end else begin
                    w_baud_nxt = r_baud - 9'd1;
                end
            end
            c_st_data: begin
                w_txd_nxt = r_shift[0];
                if (w_baud_zero) begin
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    w_baud_nxt   = c_baud_reload;
                    if (r_bitcnt == c_last_bit) begin
                        w_state_nxt = c_st_stop;
                    end
                end else begin
                    w_baud_nxt = r_baud - 9'd1;
                end
            end
            c_st_stop: begin
                w_txd_nxt = 1'b1;
                if (w_baud_zero) begin
                    // Chain straight into the next frame when data is waiting
                    if (!w_empty && !flush) begin
                        w_pop        = 1'b1;
                        w_state_nxt  = c_st_start;
                        w_baud_nxt   = c_baud_reload;
                        w_bitcnt_nxt = 3'd0;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end else begin
                    w_baud_nxt = r_baud - 9'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_baud   <= 9'd0;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'd0;
            r_txd    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_txd    <= w_txd_nxt;
        end
    end

    // Flush clears the flag and also suppresses a same-cycle drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (flush) begin
            r_ovf <= 1'b0;
        end else if (push && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign ovf      = r_ovf;
    assign tx_busy  = (r_state != c_st_idle);
    assign uart_txd = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ctrl_uart_tx_fifo
// Description : Self-checking bench for ctrl_uart_tx_fifo. A fast instance
//               (4 clocks per bit) covers framing, FIFO full/overflow, flush
//               and async reset; a default-rate instance is decoded by a
//               mid-bit sampling receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_uart_tx_fifo;

    localparam int AW = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;

    // Fast instance
    logic        push     = 1'b0;
    logic [7:0]  push_dat = 8'd0;
    logic        flush    = 1'b0;
    logic        full, empty, ovf, tx_busy, uart_txd;
    logic [AW:0] level;

    // Default-rate instance
    logic        push_b     = 1'b0;
    logic [7:0]  push_dat_b = 8'd0;
    logic        flush_b    = 1'b0;
    logic        full_b, empty_b, ovf_b, tx_busy_b, uart_txd_b;
    logic [AW:0] level_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_uart_tx_fifo #(.AW(AW), .TXD_CNT(9'd4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .tx_busy  (tx_busy),
        .uart_txd (uart_txd)
    );

    ctrl_uart_tx_fifo #(.AW(AW)) u_dut_slow (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_b),
        .push_dat (push_dat_b),
        .flush    (flush_b),
        .full     (full_b),
        .empty    (empty_b),
        .level    (level_b),
        .ovf      (ovf_b),
        .tx_busy  (tx_busy_b),
        .uart_txd (uart_txd_b)
    );

    typedef struct {
        logic [7:0] dat;
        logic [0:9] frame;   // line order: start, d0..d7, stop
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        push     = 1'b1;
        push_dat = d;
        tick();
        push     = 1'b0;
    endtask

    function automatic logic [0:9] frame_of(input logic [7:0] b);
        logic [0:9] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9] = 1'b1;
        return f;
    endfunction

    // Checks 40 consecutive line samples (10 bits x 4 clocks)
    task automatic check_line40(input logic [0:9] exp, input string tag);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check($sformatf("%s_bit%0d", tag, b), 32'(uart_txd), 32'(exp[b]));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        int         k;

        vecs[0] = '{8'hA5, 10'b0101001011};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h3C, 10'b0001111001};
        vecs[4] = '{8'h81, 10'b0100000011};

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        #1;
        check("rst_txd",   32'(uart_txd), 32'd1);
        check("rst_level", 32'(level),    32'd0);
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_full",  32'(full),     32'd0);
        check("rst_ovf",   32'(ovf),      32'd0);
        check("rst_busy",  32'(tx_busy),  32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // ---------------- single frames from table ----------------
        for (int v = 0; v < 5; v++) begin
            push_byte(vecs[v].dat);                       // edge N
            check($sformatf("t2_v%0d_level_push", v), 32'(level), 32'd1);
            tick();                                        // edge N+1: popped
            check($sformatf("t2_v%0d_txd_n1", v),  32'(uart_txd), 32'd1);
            check($sformatf("t2_v%0d_busy_n1", v), 32'(tx_busy),  32'd1);
            check($sformatf("t2_v%0d_level_pop", v), 32'(level), 32'd0);
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < 4; c++) begin
                    tick();
                    check($sformatf("t2_v%0d_bit%0d", v, b), 32'(uart_txd), 32'(vecs[v].frame[b]));
                    if (b == 9 && c == 2)
                        check($sformatf("t2_v%0d_busy_end", v), 32'(tx_busy), 32'd1);
                    if (b == 9 && c == 3)
                        check($sformatf("t2_v%0d_busy_drop", v), 32'(tx_busy), 32'd0);
                end
            end
            tick();
        end

        // ---------------- fill to full while busy, overflow, gapless drain ----------------
        check("t3_ovf_before", 32'(ovf), 32'd0);
        push_byte(8'hEE);
        fork
            begin
                tick();
                check("t3_ee_txd_n1", 32'(uart_txd), 32'd1);
                check_line40(frame_of(8'hEE), "t3_ee");
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    push     = 1'b1;
                    push_dat = 8'(i);
                    tick();
                end
                push = 1'b0;
                check("t3_level_full", 32'(level), 32'd16);
                check("t3_full",       32'(full),  32'd1);
                check("t3_ovf",        32'(ovf),   32'd1);
            end
        join
        for (int i = 0; i < 16; i++) begin
            check_line40(frame_of(8'(i)), $sformatf("t3_q%0d", i));
        end
        check("t3_busy_done",  32'(tx_busy), 32'd0);
        check("t3_empty_done", 32'(empty),   32'd1);
        tick();
        check("t3_idle_txd", 32'(uart_txd), 32'd1);

        // ---------------- flush mid-frame ----------------
        push_byte(8'hC3);
        fork
            begin
                tick();
                check("t5_txd_n1", 32'(uart_txd), 32'd1);
                check_line40(frame_of(8'hC3), "t5_c3");
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    push     = 1'b1;
                    push_dat = 8'h10 + 8'(i);
                    tick();
                end
                push = 1'b0;
                check("t5_level5", 32'(level), 32'd5);
                repeat (4) tick();
                check("t5_ovf_pre", 32'(ovf), 32'd1);
                flush = 1'b1;
                tick();
                flush = 1'b0;
                check("t5_level0", 32'(level),   32'd0);
                check("t5_empty",  32'(empty),   32'd1);
                check("t5_ovf",    32'(ovf),     32'd0);
                check("t5_busy",   32'(tx_busy), 32'd1);
            end
        join
        check("t5_busy_done", 32'(tx_busy), 32'd0);
        repeat (3) tick();
        check("t5_idle_txd",  32'(uart_txd), 32'd1);
        check("t5_idle_busy", 32'(tx_busy),  32'd0);

        // ---------------- push dropped on full despite same-cycle pop ----------------
        for (int i = 0; i < 17; i++) push_byte(8'h00);    // edges N..N+16
        check("t4_level16", 32'(level), 32'd16);
        check("t4_full",    32'(full),  32'd1);
        check("t4_ovf0",    32'(ovf),   32'd0);
        repeat (24) tick();                               // edge N+40
        check("t4_level16b", 32'(level), 32'd16);
        push_byte(8'h77);                                 // edge N+41: pop + dropped push
        check("t4_level15", 32'(level),   32'd15);
        check("t4_ovf1",    32'(ovf),     32'd1);
        check("t4_notfull", 32'(full),    32'd0);
        check("t4_busy",    32'(tx_busy), 32'd1);

        // ---------------- async reset mid-DATA ----------------
        repeat (10) tick();
        check("t1_txd_data", 32'(uart_txd), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t1_txd",   32'(uart_txd), 32'd1);
        check("t1_level", 32'(level),    32'd0);
        check("t1_ovf",   32'(ovf),      32'd0);
        check("t1_busy",  32'(tx_busy),  32'd0);
        check("t1_empty", 32'(empty),    32'd1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t1_post_txd", 32'(uart_txd), 32'd1);

        // ---------------- default bit period with mid-bit receiver ----------------
        push_b     = 1'b1;
        push_dat_b = 8'h55;
        tick();
        push_b     = 1'b0;
        k = 0;
        while (uart_txd_b !== 1'b0 && k < 10) begin
            tick();
            k++;
        end
        check("t6_fall_latency", 32'(k), 32'd2);
        repeat (217) tick();
        check("t6_start_mid", 32'(uart_txd_b), 32'd0);
        rx = 8'd0;
        for (int i = 0; i < 8; i++) begin
            repeat (434) tick();
            rx[i] = uart_txd_b;
        end
        check("t6_rx_byte", 32'(rx), 32'h55);
        repeat (434) tick();
        check("t6_stop_mid", 32'(uart_txd_b), 32'd1);
        repeat (215) tick();
        check("t6_busy_end", 32'(tx_busy_b), 32'd1);
        tick();
        check("t6_busy_drop", 32'(tx_busy_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
